// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-side memory/MMIO slave: MMIO register map,
// STATUS bit layout and address decode classes.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

    localparam logic [3:0] OFF_CYCLE  = 4'h0;
    localparam logic [3:0] OFF_TXDATA = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_MMIO
    } sel_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is still accepted
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   push_ok_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_COUNT);
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok_o = push_i && (!full_o || pop_ok);
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_o) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)    rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok_o && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok_o && pop_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_o && !reset) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-port slave: byte-writable word RAM plus a 16-byte MMIO window holding a
// cycle counter, a console TX FIFO and a status register. Reads are combinational.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int MW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] cycle_q, cycle_d;
    logic        ovf_q, ovf_d;

    sel_e        sel;
    logic [3:0]  offset;
    logic [MW-1:0] word_idx;
    logic        cycle_wr, tx_push, ovf_clr, push_ok;
    logic        fifo_full, fifo_empty;
    logic [CW:0] fifo_count;
    logic [31:0] status;

    assign word_idx = daddr[MW+1:2];
    assign offset   = {daddr[3:2], 2'b00};

    always_comb begin
        sel = SEL_NONE;
        if (daddr < RAM_BYTES)                      sel = SEL_RAM;
        else if (daddr[31:4] == MMIO_BASE[31:4])    sel = SEL_MMIO;
    end

    assign cycle_wr = (sel == SEL_MMIO) && (offset == OFF_CYCLE) && (|dwe);
    assign tx_push  = (sel == SEL_MMIO) && (offset == OFF_TXDATA) && dwe[0];
    assign ovf_clr  = (sel == SEL_MMIO) && (offset == OFF_STATUS) && dwe[0] && dwdata[2];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (tx_push),
        .wdata_i   (dwdata[7:0]),
        .pop_i     (tx_ready),
        .rdata_o   (tx_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count),
        .push_ok_o (push_ok)
    );

    assign tx_valid = !fifo_empty;

    // A dropped push sets overflow even if software clears it in the same cycle.
    always_comb begin
        cycle_d = cycle_wr ? 32'h0 : cycle_q + 32'h1;
        ovf_d   = ovf_q;
        if (ovf_clr)             ovf_d = 1'b0;
        if (tx_push && !push_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (sel == SEL_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (dwe[i]) mem_q[word_idx][8*i +: 8] <= dwdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        status                          = '0;
        status[ST_COUNT_LSB +: CW+1]    = fifo_count;
        status[ST_OVF]                  = ovf_q;
        status[ST_FULL]                 = fifo_full;
        status[ST_EMPTY]                = fifo_empty;

        drdata = 32'h0;
        case (sel)
            SEL_RAM:  drdata = mem_q[word_idx];
            SEL_MMIO: begin
                if (offset == OFF_CYCLE)       drdata = cycle_q;
                else if (offset == OFF_STATUS) drdata = status;
            end
            default:  drdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM byte lanes, cycle counter,
// TX FIFO fill/overflow/drain, concurrent push/pop, reset and unmapped space.
module tb_dmem_mmio;

    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam logic [31:0] A_CYCLE = BASE + 32'h0;
    localparam logic [31:0] A_TX    = BASE + 32'h4;
    localparam logic [31:0] A_STAT  = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int errors = 0;
    int checks = 0;

    dmem_mmio dut (
        .clk      (clk),
        .reset    (reset),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .dwe      (dwe),
        .drdata   (drdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
        daddr  = a;
        dwdata = wd;
        dwe    = we;
    endtask

    // Inputs change 1ns after the rising edge so outputs are sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] exp);
        applyStimulus(a, 32'h0, 4'h0);
        #1;
        checkOutput(tag, drdata, exp);
    endtask

    task automatic pushByte(input logic [7:0] b);
        applyStimulus(A_TX, {24'h0, b}, 4'h1);
        step();
    endtask

    initial begin
        reset    = 1'b1;
        tx_ready = 1'b0;
        applyStimulus(32'h0, 32'h0, 4'h0);
        step();
        step();
        reset = 1'b0;

        // reset state
        readCheck("rst_cycle", A_CYCLE, 32'h0);
        readCheck("rst_status", A_STAT, 32'h1);
        checkOutput("rst_txvalid", {31'h0, tx_valid}, 32'h0);

        // cycle counter
        for (int i = 0; i < 5; i++) step();
        readCheck("cycle_5", A_CYCLE, 32'd5);
        applyStimulus(A_CYCLE, 32'h1234, 4'h1);
        step();
        readCheck("cycle_clr0", A_CYCLE, 32'h0);
        step();
        readCheck("cycle_clr1", A_CYCLE, 32'h1);
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        readCheck("cycle_pre", A_CYCLE, 32'hFFFF_FFFF);
        step();
        readCheck("cycle_wrap", A_CYCLE, 32'h0);

        // RAM byte lanes
        applyStimulus(32'h10, 32'h1122_3344, 4'hF);
        step();
        applyStimulus(32'h10, 32'hAABB_CCDD, 4'b0101);
        step();
        readCheck("ram_lanes", 32'h10, 32'h11BB_33DD);
        readCheck("ram_lowbits", 32'h13, 32'h11BB_33DD);
        applyStimulus(32'h0, 32'hCAFE_F00D, 4'hF);
        step();
        readCheck("ram_word0", 32'h0, 32'hCAFE_F00D);

        // FIFO fill and overflow
        for (int i = 0; i < 8; i++) pushByte(8'h41 + 8'(i));
        readCheck("fill_status", A_STAT, 32'h82);
        readCheck("txdata_read0", A_TX, 32'h0);
        checkOutput("fill_head", {24'h0, tx_data}, 32'h41);
        pushByte(8'h49);
        readCheck("ovf_status", A_STAT, 32'h86);
        step();
        checkOutput("stall_head", {24'h0, tx_data}, 32'h41);
        applyStimulus(A_STAT, 32'h4, 4'h1);
        step();
        readCheck("ovf_clear", A_STAT, 32'h82);

        // drain order
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain_valid", {31'h0, tx_valid}, 32'h1);
            checkOutput("drain_data", {24'h0, tx_data}, 32'h41 + i);
            step();
        end
        checkOutput("drain_done", {31'h0, tx_valid}, 32'h0);
        readCheck("drain_status", A_STAT, 32'h1);

        // push while full with concurrent pop
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) pushByte(8'h61 + 8'(i));
        tx_ready = 1'b1;
        pushByte(8'h5A);
        readCheck("fullpp_status", A_STAT, 32'h82);
        for (int i = 0; i < 8; i++) begin
            checkOutput("fullpp_data", {24'h0, tx_data}, (i < 7) ? 32'h62 + i : 32'h5A);
            step();
        end
        checkOutput("fullpp_empty", {31'h0, tx_valid}, 32'h0);

        // push while empty with tx_ready high
        pushByte(8'h33);
        checkOutput("emptypp_valid", {31'h0, tx_valid}, 32'h1);
        checkOutput("emptypp_data", {24'h0, tx_data}, 32'h33);
        applyStimulus(32'h0, 32'h0, 4'h0);
        step();
        checkOutput("emptypp_gone", {31'h0, tx_valid}, 32'h0);

        // reset with queued bytes and a same-cycle push
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) pushByte(8'h70 + 8'(i));
        readCheck("q3_status", A_STAT, 32'h30);
        reset = 1'b1;
        applyStimulus(A_TX, 32'h77, 4'h1);
        step();
        reset = 1'b0;
        readCheck("rst2_status", A_STAT, 32'h1);
        checkOutput("rst2_valid", {31'h0, tx_valid}, 32'h0);

        // unmapped space
        readCheck("unmap_c", BASE + 32'hC, 32'h0);
        readCheck("unmap_4g", 32'h4000_0000, 32'h0);
        applyStimulus(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        step();
        applyStimulus(32'h4000_0000, 32'hDEAD_BEEF, 4'hF);
        step();
        readCheck("unmap_c_after", BASE + 32'hC, 32'h0);
        readCheck("unmap_4g_after", 32'h4000_0000, 32'h0);
        readCheck("unmap_ram0", 32'h0, 32'hCAFE_F00D);
        readCheck("unmap_ram3", 32'h10, 32'h11BB_33DD);
        readCheck("unmap_status", A_STAT, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Data-side slave that sits directly downstream of the CPU's data port and consumes daddr/dwdata/dwe, returning drdata.
- Contains a byte-writable word RAM.
- Contains a small MMIO window: a free-running cycle counter, a console transmit FIFO with valid/ready drain, and a status register.
- Reads are combinational, which the single-cycle core requires. Writes commit on the rising clock edge.

Parameters:
MEM_WORDS, 1024, RAM depth in 32-bit words; RAM occupies byte addresses 0 .. MEM_WORDS*4-1
FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2
MMIO_BASE, 32'h8000_0000, base of the 16-byte MMIO window; low 4 bits are zero

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
daddr  input  32  byte address from the CPU; bits [1:0] are ignored (word access)
dwdata  input  32  write data, little-endian byte lanes
dwe  input  4  byte write enables; dwe[i] writes dwdata[8i+7:8i]
drdata  output  32  combinational read data for daddr
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO not empty
tx_ready  input  1  consumer accepts tx_data this cycle

Behaviour:
- Decode:
  - RAM when daddr < MEM_WORDS*4; word index is daddr[log2(MEM_WORDS)+1:2].
  - MMIO when daddr[31:4] == MMIO_BASE[31:4]:
    - offset 0x0 = CYCLE
    - offset 0x4 = TXDATA
    - offset 0x8 = STATUS
    - offset 0xC = unmapped
  - Anywhere else is unmapped.
- Reads (combinational, no side effects):
  - RAM returns the stored word.
  - CYCLE returns the counter value.
  - TXDATA returns 0.
  - STATUS returns {zero-pad, count[log2(FIFO_DEPTH):0] at bits [4+:], overflow at [2], full at [1], empty at [0]}.
  - Unmapped addresses return 32'h0.
- RAM write: on a clock edge, each byte lane with dwe[i]=1 is updated; other lanes are held. RAM contents are not reset.
- CYCLE counter:
  - Increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - A write with any dwe bit set makes the next value 0, not 1.
- TXDATA write (dwe[0]=1) is a push of dwdata[7:0]:
  - Accepted if count < FIFO_DEPTH, or if the FIFO is full and a pop occurs the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
- STATUS write with dwe[0]=1 and dwdata[2]=1 clears overflow. If a clear and a new overflow occur in the same cycle, the overflow set wins.
- TX handshake:
  - tx_valid = !empty; tx_data = head entry.
  - A pop occurs when tx_valid && tx_ready.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
- Simultaneous push and pop:
  - count is unchanged.
  - When empty, there is no pop; the pushed byte appears as head next cycle.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Reset (synchronous, active-high):
  - counter = 0, FIFO pointers and count = 0, overflow = 0.
  - Hence tx_valid = 0 and STATUS = 32'h1 on the first cycle after reset.
  - drdata follows the decode rules.
  - Reset mid-operation discards queued bytes; any same-cycle writes to MMIO are ignored.
  - Whether same-cycle RAM writes during reset commit is unspecified and not checked.
- Writes to unmapped addresses or to CYCLE with dwe=0 are no-ops.

Decomposition:
- Shared package holds:
  - MMIO offsets: OFF_CYCLE=4'h0, OFF_TXDATA=4'h4, OFF_STATUS=4'h8.
  - STATUS bit positions: ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_COUNT_LSB=4.
  - The default MMIO_BASE.
- One sub-module, sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count, with push-when-full accepted on a concurrent pop.
- RAM, decode, counter and status live in dmem_mmio.

Test Plan:
- RAM byte lanes:
  - Write 0x1122_3344 to 0x10 with dwe=4'hF, then 0xAABB_CCDD with dwe=4'b0101. Read 0x10 -> 0x11BB_33DD.
  - Read 0x13 -> same word.
- Cycle counter:
  - Release reset; read CYCLE 5 cycles later -> 5.
  - Write CYCLE (dwe=4'h1); next-cycle read -> 0, following cycle -> 1.
  - Preload near wrap by forcing the counter to 0xFFFF_FFFF; the next read is 0.
- FIFO fill and overflow (tx_ready=0):
  - Push bytes 0x41..0x48 -> STATUS = 0x82 (count 8, full).
  - Push 0x49 -> STATUS = 0x86, byte dropped.
  - Clear overflow -> STATUS = 0x82.
- Drain order:
  - Raise tx_ready -> tx_data yields 0x41..0x48 on consecutive cycles; tx_valid drops after 0x48; STATUS = 0x1.
- Simultaneous push and pop:
  - When full with tx_ready=1, push 0x5A -> accepted, no overflow, count stays 8, 0x5A drained last.
  - When empty, push 0x33 -> tx_valid=1 and tx_data=0x33 next cycle.
- Reset and unmapped:
  - Assert reset with 3 bytes queued -> tx_valid=0 and STATUS=0x1 next cycle.
  - Read 0x8000_000C and 0x4000_0000 -> 0; a write there changes nothing.
